// File: rtl/gpio_port_pcint.sv
// Parametrised GPIO port (PINx/DDRx/PORTx) with a pin-change interrupt unit.
// Optional per-pin glitch filter: define GPIO_PC_FILTER_EN.
module gpio_port_pcint #(
  parameter int         WIDTH      = 8,
  parameter logic [5:0] PIN_ADDR   = 6'h03,
  parameter logic [5:0] PCMSK_ADDR = 6'h1C,
  parameter logic [5:0] PCCR_ADDR  = 6'h1B,
  parameter logic [7:0] PORT_RST   = 8'h00,
  parameter int         FILTER_LEN = 3
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [5:0]       IO_Addr,
  input  logic             iore,
  input  logic             iowe,
  input  logic [7:0]       dbus_in,
  output logic [7:0]       dbus_out,
  output logic             out_en,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] DIE_o,
  output logic [WIDTH-1:0] pu,
  output logic [WIDTH-1:0] dd,
  output logic [WIDTH-1:0] pv,
  output logic [WIDTH-1:0] die,
  input  logic             PUD,
  input  logic             SLEEP,
  output logic             irq,
  input  logic             irq_ack
);

  localparam logic [5:0] DDR_ADDR  = PIN_ADDR + 6'd1;
  localparam logic [5:0] PORT_ADDR = PIN_ADDR + 6'd2;
`ifdef GPIO_PC_FILTER_EN
  localparam int PRIME_N = 3 + FILTER_LEN;
`else
  localparam int PRIME_N = 3;
`endif
  localparam int                 PRIME_W   = $clog2(PRIME_N + 1);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(PRIME_N);

  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("gpio_port_pcint: WIDTH must be 1..8");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter
    $error("gpio_port_pcint: FILTER_LEN must be 2..15");
  end

  logic [WIDTH-1:0]   ddr, port, pcmsk;
  logic               pcie, pcif;
  logic [1:0]         edge_sel;
  logic [WIDTH-1:0]   sync_p1, sync_p2, pin_val, prev_p4, ev;
  logic [PRIME_W-1:0] prime_cnt;
  logic               vld_p4;
  logic               hit_pin, hit_ddr, hit_port, hit_pcmsk, hit_pccr;
  logic               pcif_clr;
  logic [WIDTH-1:0]   wdata;
  logic [7:0]         rdata;

  function automatic logic edge_match(input logic [1:0] mode, input logic was,
                                      input logic now);
    case (mode)
      2'b01:   edge_match = ~was & now;
      2'b10:   edge_match = was & ~now;
      default: edge_match = was ^ now;
    endcase
  endfunction

  assign hit_pin   = (IO_Addr == PIN_ADDR);
  assign hit_ddr   = (IO_Addr == DDR_ADDR);
  assign hit_port  = (IO_Addr == PORT_ADDR);
  assign hit_pcmsk = (IO_Addr == PCMSK_ADDR);
  assign hit_pccr  = (IO_Addr == PCCR_ADDR);
  assign wdata     = dbus_in[WIDTH-1:0];
  assign pcif_clr  = irq_ack | (iowe & hit_pccr & dbus_in[3]);

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      ddr      <= '0;
      port     <= PORT_RST[WIDTH-1:0];
      pcmsk    <= '0;
      pcie     <= 1'b0;
      edge_sel <= 2'b00;
    end else if (iowe) begin
      if (hit_ddr)   ddr   <= wdata;
      if (hit_port)  port  <= wdata;
      else if (hit_pin) port <= port ^ wdata;
      if (hit_pcmsk) pcmsk <= wdata;
      if (hit_pccr) begin
        pcie     <= dbus_in[0];
        edge_sel <= dbus_in[2:1];
      end
    end
  end

  // Pad controls
  assign dd    = ddr;
  assign pv    = port;
  assign pu    = ~ddr & port & ~{WIDTH{PUD}};
  assign die   = {WIDTH{~SLEEP}} | (pcmsk & {WIDTH{pcie}});
  assign DIE_o = pin_i & die;

  // Stage p1/p2: two-flop synchroniser on the gated pad input
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= DIE_o;
      sync_p2 <= sync_p1;
    end
  end

`ifdef GPIO_PC_FILTER_EN
  // Stage p3: filtered level follows sync_p2 only after FILTER_LEN stable differing cycles
  logic [WIDTH-1:0] filt_p3;
  logic [3:0]       filt_cnt [WIDTH];

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      filt_p3 <= '0;
      for (int n = 0; n < WIDTH; n++) filt_cnt[n] <= 4'd0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (sync_p2[n] != filt_p3[n]) begin
          if (filt_cnt[n] == 4'(FILTER_LEN - 1)) begin
            filt_p3[n]  <= sync_p2[n];
            filt_cnt[n] <= 4'd0;
          end else begin
            filt_cnt[n] <= filt_cnt[n] + 4'd1;
          end
        end else begin
          filt_cnt[n] <= 4'd0;
        end
      end
    end
  end

  assign pin_val = filt_p3;
`else
  assign pin_val = sync_p2;
`endif

  // Stage p4: previous level for edge detection; vld_p4 holds off events until the chain is full
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      prev_p4   <= '0;
      prime_cnt <= '0;
    end else begin
      prev_p4 <= pin_val;
      if (prime_cnt != PRIME_MAX) prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  assign vld_p4 = (prime_cnt == PRIME_MAX);

  always_comb begin
    ev = '0;
    for (int n = 0; n < WIDTH; n++)
      ev[n] = vld_p4 & pcmsk[n] & edge_match(edge_sel, prev_p4[n], pin_val[n]);
  end

  // A fresh event outranks a same-cycle clear so no edge is ever lost
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)       pcif <= 1'b0;
    else if (|ev)      pcif <= 1'b1;
    else if (pcif_clr) pcif <= 1'b0;
  end

  assign irq = pcif & pcie;

  always_comb begin
    rdata  = 8'h00;
    out_en = 1'b0;
    if (iore) begin
      out_en = 1'b1;
      if (hit_pin)        rdata[WIDTH-1:0] = pin_val;
      else if (hit_ddr)   rdata[WIDTH-1:0] = ddr;
      else if (hit_port)  rdata[WIDTH-1:0] = port;
      else if (hit_pcmsk) rdata[WIDTH-1:0] = pcmsk;
      else if (hit_pccr)  rdata[3:0]       = {pcif, edge_sel, pcie};
      else                out_en           = 1'b0;
    end
  end

  assign dbus_out = rdata;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// Bench for gpio_port_pcint: directed scenarios plus random traffic against a
// history-based reference model of the port and pin-change interrupt.
`timescale 1ns/1ps
module tb_gpio_port_pcint;

  localparam int         W        = 8;
  localparam logic [5:0] PIN_A    = 6'h03;
  localparam logic [5:0] DDR_A    = 6'h04;
  localparam logic [5:0] PORT_A   = 6'h05;
  localparam logic [5:0] PCMSK_A  = 6'h1C;
  localparam logic [5:0] PCCR_A   = 6'h1B;
  localparam logic [7:0] PORT_RST = 8'h00;
  localparam int         FLEN     = 3;
`ifdef GPIO_PC_FILTER_EN
  localparam bit FILT    = 1'b1;
  localparam int PRIME_N = 3 + FLEN;
  localparam int LAT     = 2 + FLEN;
`else
  localparam bit FILT    = 1'b0;
  localparam int PRIME_N = 3;
  localparam int LAT     = 2;
`endif

  logic         cp2 = 1'b0;
  logic         ireset = 1'b0;
  logic [5:0]   IO_Addr = '0;
  logic         iore = 1'b0, iowe = 1'b0;
  logic [7:0]   dbus_in = '0;
  logic [7:0]   dbus_out;
  logic         out_en;
  logic [W-1:0] pin_i = '0;
  logic [W-1:0] DIE_o, pu, dd, pv, die;
  logic         PUD = 1'b0, SLEEP = 1'b0;
  logic         irq;
  logic         irq_ack = 1'b0;

  gpio_port_pcint #(
    .WIDTH(W), .PIN_ADDR(PIN_A), .PCMSK_ADDR(PCMSK_A), .PCCR_ADDR(PCCR_A),
    .PORT_RST(PORT_RST), .FILTER_LEN(FLEN)
  ) dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en), .pin_i(pin_i),
    .DIE_o(DIE_o), .pu(pu), .dd(dd), .pv(pv), .die(die), .PUD(PUD), .SLEEP(SLEEP),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 cp2 = ~cp2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers plus histories of sampled pad levels.
  logic [7:0] m_ddr, m_port, m_pcmsk, m_filt;
  logic       m_pcie, m_pcif;
  logic [1:0] m_edge;
  logic [7:0] die_q[$];
  logic [7:0] s2_q[$];
  logic [7:0] pv_q[$];
  int         m_edges;

  function automatic logic [7:0] m_die();
    return SLEEP ? (m_pcmsk & {8{m_pcie}}) : 8'hFF;
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      PIN_A:   return pv_q[0];
      DDR_A:   return m_ddr;
      PORT_A:  return m_port;
      PCMSK_A: return m_pcmsk;
      PCCR_A:  return {4'h0, m_pcif, m_edge, m_pcie};
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_hit(input logic [5:0] a);
    return (a == PIN_A) || (a == DDR_A) || (a == PORT_A) || (a == PCMSK_A) || (a == PCCR_A);
  endfunction

  task automatic model_reset();
    m_ddr = 8'h00; m_port = PORT_RST; m_pcmsk = 8'h00; m_pcie = 1'b0;
    m_edge = 2'b00; m_pcif = 1'b0; m_filt = 8'h00; m_edges = 0;
    die_q = '{8'h00, 8'h00};
    pv_q  = '{8'h00, 8'h00};
    s2_q.delete();
    for (int i = 0; i < FLEN; i++) s2_q.push_back(8'h00);
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [7:0] a, b, ev, dn, s2, upd;
    logic       clr;
    b  = pv_q[0];
    a  = pv_q[1];
    ev = 8'h00;
    if (m_edges >= PRIME_N) begin
      case (m_edge)
        2'b01:   ev = ~a & b & m_pcmsk;
        2'b10:   ev = a & ~b & m_pcmsk;
        default: ev = (a ^ b) & m_pcmsk;
      endcase
    end
    clr = irq_ack || (iowe && IO_Addr == PCCR_A && dbus_in[3]);
    dn  = pin_i & m_die();
    if (iowe) begin
      case (IO_Addr)
        PIN_A:   m_port = m_port ^ dbus_in;
        DDR_A:   m_ddr = dbus_in;
        PORT_A:  m_port = dbus_in;
        PCMSK_A: m_pcmsk = dbus_in;
        PCCR_A:  begin m_pcie = dbus_in[0]; m_edge = dbus_in[2:1]; end
        default: ;
      endcase
    end
    if (ev != 8'h00) m_pcif = 1'b1;
    else if (clr)    m_pcif = 1'b0;
    die_q.push_front(dn);
    if (die_q.size() > 3) void'(die_q.pop_back());
    s2 = die_q[1];
    if (FILT) begin
      upd = 8'hFF;
      for (int i = 0; i < FLEN; i++) upd &= s2_q[i] ^ m_filt;
      m_filt ^= upd;
    end
    s2_q.push_front(s2);
    if (s2_q.size() > FLEN) void'(s2_q.pop_back());
    pv_q.push_front(FILT ? m_filt : s2);
    if (pv_q.size() > 2) void'(pv_q.pop_back());
    if (m_edges < 1000) m_edges++;
  endtask

  task automatic check_outputs();
    check_eq("irq", irq, m_pcif & m_pcie);
    check_eq("dd", dd, m_ddr);
    check_eq("pv", pv, m_port);
    check_eq("pu", pu, ~m_ddr & m_port & {8{~PUD}});
    check_eq("die", die, m_die());
    check_eq("die_o", DIE_o, pin_i & m_die());
  endtask

  task automatic cycle();
    model_step();
    @(posedge cp2);
    #1;
    check_outputs();
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    iowe = 1'b1; IO_Addr = a; dbus_in = d;
    cycle();
    iowe = 1'b0;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] v);
    iore = 1'b1; IO_Addr = a;
    #1;
    check_eq("out_en", out_en, m_hit(a));
    check_eq($sformatf("rd_%02h", a), dbus_out, m_read(a));
    v = dbus_out;
    iore = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic apply_reset(input int hold);
    #2 ireset = 1'b0;
    model_reset();
    #1;
    check_eq("rst_irq", irq, 0);
    check_eq("rst_dd", dd, 0);
    check_eq("rst_pv", pv, PORT_RST);
    check_eq("rst_pu", pu, 0);
    check_eq("rst_out_en", out_en, 0);
    repeat (hold) @(posedge cp2);
    #5 ireset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] rv;
  logic [5:0] addrs [5];

  initial begin
    addrs = '{PIN_A, DDR_A, PORT_A, PCMSK_A, PCCR_A};
    model_reset();
    pin_i = 8'hFF;
    repeat (2) @(posedge cp2);
    #1;
    check_eq("init_dd", dd, 0);
    check_eq("init_pv", pv, PORT_RST);
    check_eq("init_irq", irq, 0);
    #4 ireset = 1'b1;

    // Reset-time high pins with all pins masked must not raise an event
    io_write(PCMSK_A, 8'hFF);
    repeat (LAT + 8) cycle();
    io_read(PIN_A, rv);  check_eq("t1_pin", rv, 8'hFF);
    io_read(PCCR_A, rv); check_eq("t1_pcif", rv[3], 0);
    check_eq("t1_irq", irq, 0);
    io_read(DDR_A, rv);  check_eq("t1_ddr", rv, 8'h00);
    io_read(PORT_A, rv); check_eq("t1_port", rv, 8'h00);
    io_write(PCMSK_A, 8'h00);

    // Pull-up / driver control
    io_write(DDR_A, 8'h00);
    io_write(PORT_A, 8'hFF);
    PUD = 1'b0; #1 check_eq("t2_pu_on", pu, 8'hFF);
    PUD = 1'b1; #1 check_eq("t2_pu_pud", pu, 8'h00);
    PUD = 1'b0;
    io_write(DDR_A, 8'hFF);
    check_eq("t2_pu_out", pu, 8'h00);
    check_eq("t2_dd", dd, 8'hFF);
    check_eq("t2_pv", pv, 8'hFF);

    // PINx write toggles PORTx
    io_write(PORT_A, 8'h0F);
    io_write(PIN_A, 8'h33);
    io_read(PORT_A, rv); check_eq("t3_toggle", rv, 8'h3C);
    io_write(DDR_A, 8'h00);
    io_write(PORT_A, 8'h00);

    // Rising-edge interrupt, ack, falling ignored, unmasked pin ignored
    pin_i = 8'h00;
    repeat (LAT + 4) cycle();
    io_write(PCMSK_A, 8'h01);
    io_write(PCCR_A, 8'h03);
    pin_i = 8'h01;
    repeat (LAT + 3) cycle();
    check_eq("t4_irq_rise", irq, 1);
    io_read(PCCR_A, rv); check_eq("t4_pcif", rv[3], 1);
    ack();
    check_eq("t4_irq_ack", irq, 0);
    pin_i = 8'h00;
    repeat (LAT + 3) cycle();
    check_eq("t4_fall", irq, 0);
    pin_i = 8'h02;
    repeat (LAT + 3) cycle();
    pin_i = 8'h00;
    repeat (LAT + 3) cycle();
    check_eq("t4_unmasked", irq, 0);

    // Clear coinciding with a new event: the event wins
    pin_i = 8'h01;
    repeat (LAT + 3) cycle();
    pin_i = 8'h00;
    repeat (LAT + 3) cycle();
    check_eq("t5_pre", irq, 1);
    pin_i = 8'h01;
    repeat (LAT) cycle();
    io_write(PCCR_A, 8'h09);
    io_read(PCCR_A, rv); check_eq("t5_set_wins", rv[3], 1);
    io_write(PCCR_A, 8'h09);
    io_read(PCCR_A, rv); check_eq("t5_clear", rv[3], 0);

    // Sleep gating of digital inputs
    SLEEP = 1'b1;
    io_write(PCMSK_A, 8'h01);
    io_write(PCCR_A, 8'h09);
    pin_i = 8'hFF;
    #1;
    check_eq("t6_die", die, 8'h01);
    check_eq("t6_die_o", DIE_o, 8'h01);
`ifdef GPIO_PC_FILTER_EN
    pin_i = 8'h00;
    repeat (LAT + 6) cycle();
    io_write(PCCR_A, 8'h09);
    pin_i = 8'h01;
    repeat (2) cycle();
    pin_i = 8'h00;
    repeat (LAT + 6) cycle();
    io_read(PCCR_A, rv); check_eq("t6_short_pulse", rv[3], 0);
    pin_i = 8'h01;
    repeat (5) cycle();
    pin_i = 8'h00;
    repeat (LAT + 6) cycle();
    io_read(PCCR_A, rv); check_eq("t6_long_pulse", rv[3], 1);
`endif
    SLEEP = 1'b0;

    // Asynchronous reset while an interrupt is pending
    io_write(PCCR_A, 8'h09);
    pin_i = 8'h00;
    repeat (LAT + 3) cycle();
    pin_i = 8'h01;
    repeat (LAT + 3) cycle();
    check_eq("t7_pre_rst_irq", irq, 1);
    apply_reset(2);
    cycle();
    io_read(PCCR_A, rv);  check_eq("t7_pccr", rv, 8'h00);
    io_read(PCMSK_A, rv); check_eq("t7_pcmsk", rv, 8'h00);

    // Random traffic
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 12)      pin_i = 8'($urandom);
      else if (r < 30) pin_i = pin_i ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) SLEEP = ~SLEEP;
      if ($urandom_range(0, 29) == 0) PUD = ~PUD;
      r = $urandom_range(0, 99);
      if (r < 22)      io_write(addrs[$urandom_range(0, 4)], 8'($urandom));
      else if (r < 27) ack();
      else begin
        if (r < 45) io_read(addrs[$urandom_range(0, 4)], rv);
        else if (r < 50) io_read(6'($urandom_range(0, 63)), rv);
        cycle();
      end
      if (it == 750) apply_reset(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
